// File: rtl/rr_arb_mux.sv
// N-input round-robin arbiter feeding a one-entry registered output with
// valid/ready backpressure on both sides.
module rr_arb_mux #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] scan_idx;
  logic [WIDTH-1:0] grant_data;

  assign load = ~out_valid_q | out_ready;

  // Walk the channels starting at ptr, wrapping at NUM_IN; first valid wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = ptr_q;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!grant_valid && in_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == SEL_W'(NUM_IN - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_valid && (grant_idx == SEL_W'(i))) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load & rst_n;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_sel_d   = grant_idx;
        ptr_d       = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic
// against a queue-free behavioural model (pointer + scan by modular arithmetic).
module tb_rr_arb_mux;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_sel;

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    logic [N-1:0] r;
    g = model_grant();
    r = '0;
    if (rst_n && g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
  endtask

  // Advance one rising edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    int g;
    bit ld;
    g  = model_grant();
    ld = !m_valid || out_ready;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1; m_data = in_data[g*W +: W]; m_sel = g; m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #3;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || in_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_init: v=%b d=%h s=%0d r=%b want 0/00/0/0000", out_valid, out_data,
               out_sel, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    // Load a word, stall it, then reset between edges.
    @(negedge clk); in_valid = 4'b0001; in_data[7:0] = 8'h5E; out_ready = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h5E) begin
      bad++; $display("FAIL reset_preload: v=%b d=%h want 1/5e", out_valid, out_data);
    end
    @(negedge clk); in_valid = 4'b1111;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || in_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_async: v=%b d=%h s=%0d r=%b want 0/00/0/0000", out_valid, out_data,
               out_sel, in_ready);
    end
    @(negedge clk); rst_n = 1'b1; in_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0) begin
        bad++; $display("FAIL reset_idle: v=%b r=%b want 0/0000", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_single();
    reset_dut();
    in_valid = 4'b0100; in_data[23:16] = 8'hA5; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b want 0100", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
      bad++; $display("FAIL single_out: v=%b d=%h s=%0d want 1/a5/2", out_valid, out_data, out_sel);
    end
    // ptr should now be 3: with every channel requesting, ch3 wins.
    @(negedge clk); in_valid = 4'b1111;
    #1;
    total++;
    if (in_ready !== 4'b1000) begin
      bad++; $display("FAIL single_ptr: got %b want 1000", in_ready);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    in_valid = 4'b1111; in_data = 32'h13121110; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
        bad++;
        $display("FAIL rr_seq[%0d]: v=%b s=%0d d=%h want 1/%0d/%h", i, out_valid, out_sel,
                 out_data, i % 4, 8'h10 + i % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    in_valid = 4'b0010; in_data[15:8] = 8'h3C; out_ready = 1'b1;
    tick();
    @(negedge clk); in_valid = 4'b1001; in_data[7:0] = 8'h40; in_data[31:24] = 8'h43;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 4'b0) begin
        bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1) begin
        bad++; $display("FAIL bp_hold[%0d]: v=%b d=%h s=%0d want 1/3c/1", i, out_valid, out_data,
                        out_sel);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b1000) begin
      bad++; $display("FAIL bp_release: got %b want 1000", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h43 || out_sel !== 2'd3) begin
      bad++; $display("FAIL bp_swap: v=%b d=%h s=%0d want 1/43/3", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_drain();
    @(negedge clk); in_valid = '0; out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h43 || out_sel !== 2'd3) begin
      bad++; $display("FAIL drain: v=%b d=%h s=%0d want 0/43/3", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    in_valid = 4'b0100; in_data = 32'hD3D2D1D0; out_ready = 1'b1;
    tick();
    @(negedge clk); in_valid = 4'b0011;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin
      bad++; $display("FAIL wrap_ready0: got %b want 0001", in_ready);
    end
    tick();
    total++;
    if (out_sel !== 2'd0 || out_data !== 8'hD0) begin
      bad++; $display("FAIL wrap_sel0: s=%0d d=%h want 0/d0", out_sel, out_data);
    end
    @(negedge clk);
    #1;
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL wrap_ready1: got %b want 0010", in_ready);
    end
    tick();
    total++;
    if (out_sel !== 2'd1 || out_data !== 8'hD1) begin
      bad++; $display("FAIL wrap_sel1: s=%0d d=%h want 1/d1", out_sel, out_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_r = model_ready();
      total++;
      if (in_ready !== exp_r) begin
        bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_r);
      end
      tick();
      total++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== 2'(m_sel)) begin
        bad++;
        $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d want %b/%h/%0d", i, out_valid, out_data,
                 out_sel, m_valid, m_data, m_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input registered multiplexer; the successor to the combinational 2:1 mux.
- Generalised in input count and data width.
- Adds per-input valid/ready handshakes, round-robin arbitration and a one-entry output register with backpressure.
- Sits between several producer streams and one shared consumer, e.g. a shared bus or FIFO write port.

Parameters:
- WIDTH, 8: data width of every input and of the output.
- NUM_IN, 4: number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN): width of the index fields (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_IN  per-channel request; bit i belongs to channel i.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on rst_n; all state is clocked by clk.
  - While rst_n=0: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0, in_ready=0.
- Transfers:
  - An input transfer occurs on a clk edge where in_valid[i] & in_ready[i].
  - An output transfer occurs on a clk edge where out_valid & out_ready.
- Load enable:
  - load = ~out_valid | out_ready (register empty, or draining this cycle).
  - load is combinational from out_valid and out_ready.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, ... mod NUM_IN; grant goes to the first with in_valid set.
  - If no channel is valid, there is no grant.
- in_ready:
  - in_ready[g] = load & rst_n for the granted channel g; all other bits are 0.
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_valid must not depend on in_ready.
- Clock edge with a grant and load=1:
  - out_data <= data of channel g; out_sel <= g; out_valid <= 1.
  - ptr <= (g+1) mod NUM_IN.
- Clock edge with no grant and load=1: out_valid <= 0; out_data and out_sel hold their values.
- Clock edge with load=0: all state holds; out_data and out_sel are stable while out_valid & ~out_ready.
- Latency and throughput:
  - 1 cycle: a word accepted at edge k is visible on out_* after edge k.
  - One word per cycle is sustained when out_ready stays 1.
- Fairness:
  - Under continuous requests from every channel, grants rotate 0,1,...,NUM_IN-1,0.
  - No channel waits more than NUM_IN-1 grants.
- Simultaneous drain and load: when out_valid & out_ready and a grant exists, the new word replaces the old one at the same edge, with no bubble.
- ptr changes only on a successful input transfer; it is unchanged during idle cycles and stalls.
- Wrap-around: the grant to channel NUM_IN-1 sets ptr=0.
- Reset mid-operation: any pending output word is discarded; after release, arbitration restarts at channel 0.
- Input data changes on non-granted channels have no effect on any state.

Test Plan:
- Reset and idle (NUM_IN=4, WIDTH=8):
  - Stimulus: assert rst_n=0 mid-stream with out_valid=1, then release.
  - Required: out_valid=0, out_data=0x00, out_sel=0 and in_ready=4'b0000 immediately, without waiting for a clock edge.
  - Required: after release with no requests, outputs stay idle.
- Single channel:
  - Stimulus: in_valid=4'b0100, ch2 data=0xA5, out_ready=1.
  - Required: in_ready=4'b0100; one cycle later out_valid=1, out_data=0xA5, out_sel=2; ptr=3.
- Round-robin:
  - Stimulus: all four channels valid with data 0x10,0x11,0x12,0x13 held, out_ready=1 for 8 cycles.
  - Required: out_sel sequence 0,1,2,3,0,1,2,3; out_data follows the selected channel each cycle.
- Backpressure:
  - Stimulus: word 0x3C from ch1 in the register, out_ready=0 for 3 cycles, ch0 and ch3 valid.
  - Required: in_ready=0 throughout; out_data=0x3C and out_sel=1 stable.
  - Required: when out_ready rises, ch3 is granted in the same cycle (ptr=2 → first valid at or after 2 is 3).
- Drain with no new request:
  - Stimulus: out_valid=1, out_ready=1, in_valid=0.
  - Required: next cycle out_valid=0; out_data and out_sel hold their last values.
- Wrap-around and sparse requests:
  - Stimulus: ptr=3, in_valid=4'b0011.
  - Required: grant goes to ch0 and ptr becomes 1; the next grant goes to ch1.
